i2c_master_tx: RTL and testbench
================================

// Module: i2c_master_tx
// PURPOSE
//  Write-only I2C bus master: turns a start request plus a stream of bytes into
//  START, 7-bit address + W, data bytes with ACK checks, then STOP on open-drain SCL/SDA.
//  It is the initiating end of the I2C slave address/start/stop decode path.
//  It drives the slave path in loopback and generates register writes to external devices.
// PARAMETERS
//  CLK_DIV   4   clk cycles per SCL quarter-period (>=2); one bus bit = 4*CLK_DIV clk
// PORTS
//  clk        in   1  system clock
//  n_rst      in   1  async active-low reset
//  start_req  in   1  request a transfer; sampled only in IDLE
//  dev_addr   in   7  target address; captured when start_req is accepted
//  tx_data    in   8  byte to send, MSB first
//  tx_last    in   1  qualifies tx_data: final byte of the transfer
//  tx_valid   in   1  tx_data/tx_last valid
//  tx_ready   out  1  master can take a byte; transfer on tx_valid&tx_ready
//  sda_in     in   1  synchronized bus SDA, used for ACK sampling
//  scl_out    out  1  1 = release SCL, 0 = pull low
//  sda_out    out  1  1 = release SDA, 0 = pull low
//  busy       out  1  high from start_req accept until return to IDLE
//  done       out  1  1-clk pulse on return to IDLE after STOP
//  nack_err   out  1  sticky; set on any NACK, cleared on next accepted start_req
// BEHAVIOUR
//  Reset (async, n_rst=0): state IDLE, scl_out=1, sda_out=1, tx_ready=0, busy=0,
//   done=0, nack_err=0, quarter counter=0. Reset mid-transfer releases both lines at once.
//   No STOP is generated.
//  Quarter timer: counts 0..CLK_DIV-1 and advances the quarter index q0..q3.
//   Every state below runs in whole quarters.
//  States:
//   IDLE: lines released. If start_req=1, latch {dev_addr,1'b0} into the shift register,
//    clear nack_err, set busy, and go to START on the next clk.
//   START: q0-q1 SCL=1,SDA=1; q2-q3 SCL=1,SDA=0 (SDA falls while SCL high); then ADDR.
//   ADDR/DATA (8 bits each, MSB first): for each bit, q0-q1 SCL=0 with SDA=bit
//    (SDA changes only at the q0 entry); q2-q3 SCL=1. Then go to the matching ACK state.
//   ADDR_ACK/DATA_ACK: q0-q1 SCL=0,SDA=1 (released); q2-q3 SCL=1.
//    sda_in is sampled on the last clk of q2.
//    - 0 (ACK): ADDR_ACK goes to LOAD; DATA_ACK goes to STOP if the byte's last flag
//      is set, else to LOAD.
//    - 1 (NACK): set nack_err and go to STOP.
//   LOAD: SCL=0, SDA=0, tx_ready=1, no timeout. On tx_valid: latch tx_data and tx_last,
//    tx_ready=0 the next clk, go to DATA. While tx_valid=0, SCL stays low (bus held).
//   STOP: q0-q1 SCL=0,SDA=0; q2 SCL=1,SDA=0; q3 SCL=1,SDA=1 (SDA rises while SCL high).
//    Then IDLE with done=1 for one clk and busy=0 on that same clk.
//  tx_ready is high only in LOAD. tx_valid outside LOAD is ignored; bytes are not consumed.
//  start_req while busy is ignored (not queued).
//  A start_req that arrives in the same clk as the done pulse is accepted next clk, from IDLE.
//  SDA never changes while SCL is high, except the START/STOP edges.
//  Clock stretching is not supported; scl_out is never read back.
//  Outputs are registered. Line changes line up with quarter boundaries to within 1 clk.
// TESTING (CLK_DIV=4, bus pulled up, slave model ACKs addr 0x50)
//  1. start_req, dev_addr=0x50; one byte 0xA5 with tx_last=1.
//     -> START; bits 1010000,0; ACK; 10100101; ACK; STOP.
//     -> done 1 clk, nack_err=0, slave start/stop detect each pulse once.
//  2. dev_addr=0x23 (no slave) -> address NACK -> STOP right after ADDR_ACK;
//     nack_err=1 until next start_req, tx_ready never asserted.
//  3. Two bytes 0x01,0xFF; tx_valid for byte 2 held low 100 clk.
//     -> SCL low for the whole stall, tx_ready high throughout, then 0xFF sent and STOP.
//  4. start_req pulsed during DATA -> ignored; exactly one START on the bus; done pulses once.
//  5. n_rst low in DATA bit 3 -> scl_out=sda_out=1, busy=0 the same clk.
//     After release, a new transfer works normally.
//  6. Slave NACKs data byte 1 of 3 -> STOP after that ACK slot, bytes 2-3 not consumed,
//     nack_err=1.

Source files
------------

// File: rtl/i2c_master_tx.sv
// ----------------------------------------------------------------------------
// i2c_master_tx
// Write-only I2C bus master. A start request plus a stream of bytes becomes
// START, 7-bit address + W, data bytes with ACK checks, then STOP, driven onto
// open-drain SCL/SDA (1 = release, 0 = pull low).
//
// Ports
//   clk        system clock
//   n_rst      asynchronous active-low reset
//   start_req  request a transfer (sampled only while idle)
//   dev_addr   7-bit target address, captured when start_req is accepted
//   tx_data    byte to send, MSB first
//   tx_last    marks tx_data as the final byte of the transfer
//   tx_valid   tx_data/tx_last valid
//   tx_ready   master can take a byte (transfer on tx_valid & tx_ready)
//   sda_in     synchronized bus SDA, used for ACK sampling
//   scl_out    SCL drive
//   sda_out    SDA drive
//   busy       high from start_req accept until back in idle
//   done       one-clk pulse on return to idle after STOP
//   nack_err   sticky NACK flag, cleared on the next accepted start_req
// ----------------------------------------------------------------------------
module i2c_master_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start_req,
    input  logic [6:0] dev_addr,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       sda_in,
    output logic       scl_out,
    output logic       sda_out,
    output logic       busy,
    output logic       done,
    output logic       nack_err
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_LOAD,
        ST_DATA,
        ST_DATA_ACK,
        ST_STOP
    } state_t;

    state_t          state_reg, state_next;
    logic [DW-1:0]   div_reg, div_next;
    logic [1:0]      q_reg, q_next;
    logic [2:0]      bit_reg, bit_next;
    logic [7:0]      shift_reg, shift_next;
    logic            last_reg, last_next;
    logic            ack_reg, ack_next;
    logic            nack_reg, nack_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;
    logic            ready_reg, ready_next;
    logic            scl_reg, scl_next;
    logic            sda_reg, sda_next;

    logic            q_end;
    logic            phase_end;

    assign q_end     = (div_reg == DIV_MAX);
    assign phase_end = q_end && (q_reg == 2'd3);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= ST_IDLE;
            div_reg   <= '0;
            q_reg     <= 2'd0;
            bit_reg   <= 3'd0;
            shift_reg <= 8'd0;
            last_reg  <= 1'b0;
            ack_reg   <= 1'b1;
            nack_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            ready_reg <= 1'b0;
            scl_reg   <= 1'b1;
            sda_reg   <= 1'b1;
        end else begin
            state_reg <= state_next;
            div_reg   <= div_next;
            q_reg     <= q_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            last_reg  <= last_next;
            ack_reg   <= ack_next;
            nack_reg  <= nack_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            ready_reg <= ready_next;
            scl_reg   <= scl_next;
            sda_reg   <= sda_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. States change only at the end of q3 (or from the
    // untimed IDLE/LOAD states), so the quarter timer is already back at
    // zero whenever a new state is entered.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        div_next   = div_reg;
        q_next     = q_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        last_next  = last_reg;
        ack_next   = ack_reg;
        nack_next  = nack_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;

        if (state_reg == ST_IDLE || state_reg == ST_LOAD) begin
            div_next = '0;
            q_next   = 2'd0;
        end else if (q_end) begin
            div_next = '0;
            q_next   = q_reg + 2'd1;
        end else begin
            div_next = div_reg + 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (start_req) begin
                    shift_next = {dev_addr, 1'b0};
                    nack_next  = 1'b0;
                    busy_next  = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (phase_end) begin
                    bit_next   = 3'd0;
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR, ST_DATA: begin
                if (phase_end) begin
                    shift_next = {shift_reg[6:0], 1'b0};
                    if (bit_reg == 3'd7) begin
                        bit_next   = 3'd0;
                        state_next = (state_reg == ST_ADDR) ? ST_ADDR_ACK : ST_DATA_ACK;
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end
            end
            ST_ADDR_ACK, ST_DATA_ACK: begin
                // SCL has been high for most of q2 by its last clk
                if (q_reg == 2'd2 && q_end) begin
                    ack_next = sda_in;
                end
                if (phase_end) begin
                    if (ack_reg) begin
                        nack_next  = 1'b1;
                        state_next = ST_STOP;
                    end else if (state_reg == ST_DATA_ACK && last_reg) begin
                        state_next = ST_STOP;
                    end else begin
                        state_next = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (tx_valid && ready_reg) begin
                    shift_next = tx_data;
                    last_next  = tx_last;
                    bit_next   = 3'd0;
                    state_next = ST_DATA;
                end
            end
            ST_STOP: begin
                if (phase_end) begin
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // tx_ready is registered but tracks LOAD exactly: it rises on the clk
    // LOAD is entered and drops on the clk after the handshake.
    assign ready_next = (state_next == ST_LOAD);

    // ------------------------------------------------------------------
    // Line levels per state/quarter; registered, so the pins trail the
    // quarter boundaries by one clk.
    // ------------------------------------------------------------------
    always_comb begin
        scl_next = 1'b1;
        sda_next = 1'b1;
        case (state_reg)
            ST_START: begin
                sda_next = ~q_reg[1];
            end
            ST_ADDR, ST_DATA: begin
                scl_next = q_reg[1];
                sda_next = shift_reg[7];
            end
            ST_ADDR_ACK, ST_DATA_ACK: begin
                scl_next = q_reg[1];
            end
            ST_LOAD: begin
                scl_next = 1'b0;
                sda_next = 1'b0;
            end
            ST_STOP: begin
                scl_next = q_reg[1];
                sda_next = (q_reg == 2'd3);
            end
            default: begin
                scl_next = 1'b1;
                sda_next = 1'b1;
            end
        endcase
    end

    assign tx_ready = ready_reg;
    assign scl_out  = scl_reg;
    assign sda_out  = sda_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign nack_err = nack_reg;

endmodule

// File: tb/tb_i2c_master_tx.sv
// ----------------------------------------------------------------------------
// tb_i2c_master_tx
// Drives i2c_master_tx against a bus-level slave model (ACKs address 0x50,
// optionally NACKs one data byte). Expected bus bytes, consumed byte count
// and error flag are derived from the transfer parameters alone.
// ----------------------------------------------------------------------------
module tb_i2c_master_tx;

    localparam int          CLK_DIV = 4;
    localparam logic [6:0]  SLV     = 7'h50;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       start_req = 1'b0;
    logic [6:0] dev_addr = 7'd0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_last = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, scl_out, sda_out, busy, done, nack_err;
    logic       sda_bus;
    logic       slave_pull = 1'b0;

    assign sda_bus = sda_out & ~slave_pull;

    always #5 clk = ~clk;

    i2c_master_tx #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start_req (start_req),
        .dev_addr  (dev_addr),
        .tx_data   (tx_data),
        .tx_last   (tx_last),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .sda_in    (sda_bus),
        .scl_out   (scl_out),
        .sda_out   (sda_out),
        .busy      (busy),
        .done      (done),
        .nack_err  (nack_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Slave / bus monitor
    // ------------------------------------------------------------------
    int         nack_idx = 0;     // data byte (1-based) the slave refuses, 0 = none
    logic [7:0] got_q[$];
    int         start_cnt = 0, stop_cnt = 0, done_cnt = 0, done_busy_bad = 0, width_bad = 0;
    int         cyc_cnt = 0, rise_t = 0;
    logic       rise_valid = 1'b0;
    logic       prev_scl = 1'b1, prev_sda = 1'b1;
    logic       in_frame = 1'b0, ack_phase = 1'b0, addressed = 1'b0;
    int         bitn = 0, byten = 0;
    logic [7:0] shreg = 8'd0;

    always @(negedge clk) begin
        cyc_cnt  <= cyc_cnt + 1;
        prev_scl <= scl_out;
        prev_sda <= sda_bus;
        if (done) begin
            done_cnt <= done_cnt + 1;
            if (busy) done_busy_bad <= done_busy_bad + 1;
        end
        if (!n_rst) begin
            in_frame   <= 1'b0;
            ack_phase  <= 1'b0;
            slave_pull <= 1'b0;
            rise_valid <= 1'b0;
        end else if (prev_scl && scl_out && prev_sda && !sda_bus) begin
            start_cnt  <= start_cnt + 1;
            in_frame   <= 1'b1;
            bitn       <= 0;
            byten      <= 0;
            ack_phase  <= 1'b0;
            slave_pull <= 1'b0;
            rise_valid <= 1'b0;
        end else if (prev_scl && scl_out && !prev_sda && sda_bus) begin
            stop_cnt <= stop_cnt + 1;
            in_frame <= 1'b0;
        end else if (!prev_scl && scl_out) begin
            rise_t     <= cyc_cnt;
            rise_valid <= 1'b1;
            if (in_frame && bitn < 8) begin
                shreg <= {shreg[6:0], sda_bus};
                bitn  <= bitn + 1;
            end
        end else if (prev_scl && !scl_out) begin
            if (rise_valid && (cyc_cnt - rise_t) != 2 * CLK_DIV) width_bad <= width_bad + 1;
            rise_valid <= 1'b0;
            if (in_frame) begin
                if (ack_phase) begin
                    slave_pull <= 1'b0;
                    ack_phase  <= 1'b0;
                    bitn       <= 0;
                end else if (bitn == 8) begin
                    got_q.push_back(shreg);
                    ack_phase <= 1'b1;
                    byten     <= byten + 1;
                    if (byten == 0) begin
                        addressed  <= (shreg[7:1] == SLV) && !shreg[0];
                        slave_pull <= (shreg[7:1] == SLV) && !shreg[0];
                    end else begin
                        slave_pull <= addressed && (byten != nack_idx);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // One transfer: n bytes, slave NACKs data byte k (0 = none), byte 2
    // held back for 'stall' clks, optional stray start_req during DATA,
    // optional reset rst_cyc clks into the first data byte.
    // ------------------------------------------------------------------
    task automatic run_xfer(input logic [6:0] a, input int n, input int k, input int b0,
                            input int b1, input int stall, input bit glitch, input int rst_cyc);
        logic [7:0] data [4];
        logic [7:0] exp_q[$];
        int   exp_cons, idx, cyc, stall_bad, d;
        int   s_start, s_stop, s_done, s_dbb, s_width, s_got;
        logic exp_nack, fin, ready_seen, is_addr;

        for (int i = 0; i < 4; i++) data[i] = 8'($urandom);
        if (b0 >= 0) data[0] = b0[7:0];
        if (b1 >= 0) data[1] = b1[7:0];
        if (rst_cyc > 0) data[0] = 8'h00;
        nack_idx = k;

        s_start = start_cnt; s_stop = stop_cnt; s_done = done_cnt;
        s_dbb = done_busy_bad; s_width = width_bad; s_got = got_q.size();

        // reference: what must appear on the bus and be consumed
        is_addr  = (a == SLV);
        exp_q.push_back({a, 1'b0});
        exp_cons = 0;
        exp_nack = !is_addr;
        if (is_addr) begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back(data[i]);
                exp_cons++;
                if (k == i + 1) begin
                    exp_nack = 1'b1;
                    break;
                end
            end
        end

        @(negedge clk);
        start_req = 1'b1;
        dev_addr  = a;
        @(negedge clk);
        start_req = 1'b0;
        dev_addr  = 7'($urandom);
        check("busy_on", busy, 1);
        check("nack_clr", nack_err, 0);

        idx = 0; cyc = 0; fin = 1'b0; ready_seen = 1'b0; stall_bad = 0;
        while (!fin && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                fin = 1'b1;
            end else if (tx_ready && idx < n) begin
                ready_seen = 1'b1;
                d = (idx == 1 && stall > 0) ? stall : int'($urandom_range(0, 3));
                for (int j = 0; j < d; j++) begin
                    @(negedge clk);
                    cyc++;
                    if (scl_out !== 1'b0 || tx_ready !== 1'b1) stall_bad++;
                end
                tx_data  = data[idx];
                tx_last  = (idx == n - 1);
                tx_valid = 1'b1;
                @(negedge clk);
                cyc++;
                tx_valid = 1'b0;
                tx_data  = 8'($urandom);
                idx++;
                if (idx == 1 && rst_cyc > 0) begin
                    repeat (rst_cyc) @(negedge clk);
                    n_rst = 1'b0;
                    #1;
                    check("rst_scl", scl_out, 1);
                    check("rst_sda", sda_out, 1);
                    check("rst_busy", busy, 0);
                    check("rst_ready", tx_ready, 0);
                    repeat (3) @(negedge clk);
                    n_rst = 1'b1;
                    repeat (2) @(negedge clk);
                    $display("xfer addr=%02h reset mid-byte", a);
                    return;
                end
                if (idx == 1 && glitch) begin
                    repeat (5) @(negedge clk);
                    start_req = 1'b1;
                    dev_addr  = 7'($urandom);
                    @(negedge clk);
                    start_req = 1'b0;
                    cyc += 6;
                end
            end
        end
        check("timeout", fin, 1);
        check("busy_at_done", busy, 0);
        @(negedge clk);
        check("done_width", done, 0);
        repeat (2) @(negedge clk);

        check("nack_err", nack_err, exp_nack);
        check("starts", start_cnt - s_start, 1);
        check("stops", stop_cnt - s_stop, 1);
        check("done_cnt", done_cnt - s_done, 1);
        check("done_busy", done_busy_bad - s_dbb, 0);
        check("scl_width", width_bad - s_width, 0);
        check("consumed", idx, exp_cons);
        check("stall_hold", stall_bad, 0);
        check("ready_seen", ready_seen, is_addr);
        check("nbytes", got_q.size() - s_got, exp_q.size());
        for (int i = 0; i < exp_q.size() && s_got + i < got_q.size(); i++)
            check("byte", got_q[s_got + i], exp_q[i]);
        $display("xfer addr=%02h n=%0d nack_at=%0d bytes_on_bus=%0d consumed=%0d nack_err=%0d",
                 a, n, k, got_q.size() - s_got, idx, nack_err);
    endtask

    initial begin
        logic [6:0] ra;
        int rn, rk;

        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_scl", scl_out, 1);
        check("reset_sda", sda_out, 1);
        check("reset_ready", tx_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_nack", nack_err, 0);
        n_rst = 1'b1;
        @(negedge clk);

        run_xfer(SLV, 1, 0, 'hA5, -1, 0, 1'b0, 0);       // single byte
        run_xfer(7'h23, 2, 0, -1, -1, 0, 1'b0, 0);       // address NACK
        repeat (20) @(negedge clk);
        check("nack_sticky", nack_err, 1);
        run_xfer(SLV, 2, 0, 'h01, 'hFF, 100, 1'b0, 0);   // long stall on byte 2
        run_xfer(SLV, 2, 0, -1, -1, 0, 1'b1, 0);         // stray start_req
        run_xfer(SLV, 2, 0, -1, -1, 0, 1'b0, 54);        // reset in DATA bit 3
        run_xfer(SLV, 2, 0, -1, -1, 0, 1'b0, 0);         // recovery
        run_xfer(SLV, 3, 1, -1, -1, 0, 1'b0, 0);         // data NACK on byte 1

        for (int t = 0; t < 12; t++) begin
            ra = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SLV;
            if (ra == SLV && t % 5 == 4) ra = 7'h51;
            rn = int'($urandom_range(1, 4));
            rk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, rn)) : 0;
            run_xfer(ra, rn, rk, -1, -1, 0, 1'b0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
